// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control tokens, symbol type and link sequencer states.
package tmds_pkg;
  typedef logic [9:0] sym_t;
  localparam sym_t CTL00 = 10'b1101010100;
  localparam sym_t CTL01 = 10'b0010101011;
  localparam sym_t CTL10 = 10'b0101010100;
  localparam sym_t CTL11 = 10'b1010101011;
  typedef enum logic [2:0] {IDLE, LOCK_STABLE, SERDES_RST, FLUSH, RUN} link_state_t;
endpackage

// File: rtl/hpd_conditioner.sv
// hpd_conditioner: 2-flop synchronizer with optional stability debounce (HPD_DEBOUNCE_EN).
module hpd_conditioner #(
  parameter bit DEBOUNCE = 1'b1,
  parameter int CYCLES   = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
`ifdef HPD_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam int CW = $clog2(CYCLES) + 1;
  logic [1:0]    sync;
  logic          held;
  logic [CW-1:0] cnt;
  // held only follows the synchronized input once it has differed for CYCLES cycles in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      held <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], d};
      if (sync[1] == held) cnt <= '0;
      else if (cnt == CW'(CYCLES - 1)) begin
        held <= sync[1];
        cnt  <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign q = (DB && DEBOUNCE) ? held : sync[1];
endmodule

// File: rtl/hdmi_link_sequencer.sv
// hdmi_link_sequencer: TMDS lane bring-up (lock qualify, serdes reset, CTL flush, run); HPD debounce via HPD_DEBOUNCE_EN.
module hdmi_link_sequencer
  import tmds_pkg::*;
#(
  parameter int LOCK_CYCLES     = 256,
  parameter int RST_CYCLES      = 16,
  parameter int FLUSH_CYCLES    = 64,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       mmcm_locked,
  input  logic       hpd_in,
  input  logic [9:0] enc_ch0,
  input  logic [9:0] enc_ch1,
  input  logic [9:0] enc_ch2,
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2,
  output logic       serdes_rst,
  output logic       link_up
);
  localparam int MAXC = (LOCK_CYCLES > RST_CYCLES) ?
                        ((LOCK_CYCLES > FLUSH_CYCLES) ? LOCK_CYCLES : FLUSH_CYCLES) :
                        ((RST_CYCLES > FLUSH_CYCLES) ? RST_CYCLES : FLUSH_CYCLES);
  localparam int CW = $clog2(MAXC) + 1;
  logic          lock_s, hpd_s, ok;
  logic [CW-1:0] cnt;
  link_state_t   state, next;
  hpd_conditioner #(.DEBOUNCE(1'b0)) u_lock (
    .clk(pixel_clk), .rst_n(rst_n), .d(mmcm_locked), .q(lock_s)
  );
  hpd_conditioner #(.DEBOUNCE(1'b1), .CYCLES(DEBOUNCE_CYCLES)) u_hpd (
    .clk(pixel_clk), .rst_n(rst_n), .d(hpd_in), .q(hpd_s)
  );
  assign ok = lock_s && hpd_s;
  // losing lock or HPD beats every expiry transition
  always_comb begin
    next = state;
    case (state)
      IDLE:        next = ok ? LOCK_STABLE : IDLE;
      LOCK_STABLE: next = !ok ? IDLE : (cnt == CW'(LOCK_CYCLES - 1)) ? SERDES_RST : LOCK_STABLE;
      SERDES_RST:  next = !ok ? IDLE : (cnt == CW'(RST_CYCLES - 1)) ? FLUSH : SERDES_RST;
      FLUSH:       next = !ok ? IDLE : (cnt == CW'(FLUSH_CYCLES - 1)) ? RUN : FLUSH;
      RUN:         next = ok ? RUN : IDLE;
      default:     next = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      serdes_rst <= 1'b1;
      link_up    <= 1'b0;
      tmds_ch0   <= CTL00;
      tmds_ch1   <= CTL00;
      tmds_ch2   <= CTL00;
    end else begin
      state      <= next;
      cnt        <= (next != state) ? '0 : (&cnt) ? cnt : cnt + 1'b1;
      serdes_rst <= !(next == FLUSH || next == RUN);
      link_up    <= next == RUN;
      tmds_ch0   <= (next == RUN) ? enc_ch0 : CTL00;
      tmds_ch1   <= (next == RUN) ? enc_ch1 : CTL00;
      tmds_ch2   <= (next == RUN) ? enc_ch2 : CTL00;
    end
  end
endmodule

// File: tb/tb_hdmi_link_sequencer.sv
// tb_hdmi_link_sequencer: scenario tasks with a scoreboard for lane video.
module tb_hdmi_link_sequencer;
  localparam logic [9:0] CTL = 10'b1101010100;
`ifdef HPD_DEBOUNCE_EN
  localparam int DBO = 1024;
`else
  localparam int DBO = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, locked = 1'b0, hpd = 1'b0;
  logic [9:0] e0 = '0, e1 = '0, e2 = '0;
  logic [9:0] t0, t1, t2;
  logic srst, lup;
  int passed = 0, total = 0;
  logic [29:0] sb[$];
  always #5 clk = ~clk;
  hdmi_link_sequencer dut (
    .pixel_clk(clk), .rst_n(rst_n), .mmcm_locked(locked), .hpd_in(hpd),
    .enc_ch0(e0), .enc_ch1(e1), .enc_ch2(e2),
    .tmds_ch0(t0), .tmds_ch1(t1), .tmds_ch2(t2),
    .serdes_rst(srst), .link_up(lup)
  );
  task automatic edges_until(input bit on_link, input logic val, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (((on_link ? lup : srst) !== val) && n < limit);
  endtask
  task automatic test_reset();
    rst_n = 1'b0; locked = 1'b1; hpd = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if (srst !== 1'b1) $display("FAIL reset_srst: got %b want 1", srst); else passed++;
    total++; if (lup !== 1'b0) $display("FAIL reset_link: got %b want 0", lup); else passed++;
    total++; if (t0 !== CTL) $display("FAIL reset_ch0: got %h want %h", t0, CTL); else passed++;
    total++; if (t1 !== CTL) $display("FAIL reset_ch1: got %h want %h", t1, CTL); else passed++;
    total++; if (t2 !== CTL) $display("FAIL reset_ch2: got %h want %h", t2, CTL); else passed++;
  endtask
  task automatic test_bringup(input string tag);
    int n;
    @(negedge clk); rst_n = 1'b1;
    edges_until(1'b0, 1'b0, 3000, n);
    total++; if (n !== 275 + DBO) $display("FAIL %s_srst_fall: got %0d edges want %0d", tag, n, 275 + DBO); else passed++;
    total++; if (t0 !== CTL || lup !== 1'b0) $display("FAIL %s_flush: got ch0=%h link=%b want %h/0", tag, t0, lup, CTL); else passed++;
    edges_until(1'b1, 1'b1, 200, n);
    total++; if (n !== 64) $display("FAIL %s_link_rise: got %0d edges want 64", tag, n); else passed++;
    total++; if (srst !== 1'b0) $display("FAIL %s_run_srst: got %b want 0", tag, srst); else passed++;
  endtask
  task automatic test_video(input int count, input string tag);
    logic [29:0] exp;
    logic [9:0] v0, v1, v2;
    sb.delete();
    for (int i = 0; i <= count; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        total++;
        if ({t2, t1, t0} !== exp) $display("FAIL %s_lanes[%0d]: got %h want %h", tag, i, {t2, t1, t0}, exp);
        else passed++;
      end
      if (i < count) begin
        v0 = (i == 0) ? 10'h2AB : 10'($urandom_range(1023));
        v1 = (i == 0) ? 10'h155 : 10'($urandom_range(1023));
        v2 = (i == 0) ? 10'h3FF : 10'($urandom_range(1023));
        e0 = v0; e1 = v1; e2 = v2;
        sb.push_back({v2, v1, v0});
      end
    end
  endtask
  task automatic test_lock_glitch();
    int n;
    @(negedge clk); locked = 1'b0;
    @(posedge clk); #1; locked = 1'b1;
    edges_until(1'b1, 1'b0, 10, n);
    total++; if (n + 1 !== 3) $display("FAIL glitch_drop: got %0d edges want 3", n + 1); else passed++;
    total++; if (srst !== 1'b1) $display("FAIL glitch_srst: got %b want 1", srst); else passed++;
    edges_until(1'b1, 1'b1, 600, n);
    total++; if (n !== 337) $display("FAIL glitch_reseq: got %0d edges want 337", n); else passed++;
  endtask
`ifndef HPD_DEBOUNCE_EN
  task automatic test_flush_abort();
    bit seen = 1'b0;
    @(negedge clk); hpd = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    total++; if (lup !== 1'b0) $display("FAIL hpd_drop: got %b want 0", lup); else passed++;
    @(negedge clk); hpd = 1'b1;
    repeat (336) @(posedge clk);
    @(negedge clk); hpd = 1'b0;
    @(posedge clk); #1;
    total++; if (srst !== 1'b0) $display("FAIL pre_expiry_flush: got srst=%b want 0", srst); else passed++;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (lup) seen = 1'b1;
      if (i == 1) begin
        total++; if (srst !== 1'b1) $display("FAIL abort_wins: got srst=%b want 1", srst); else passed++;
      end
    end
    total++; if (seen !== 1'b0) $display("FAIL no_link_pulse: got %b want 0", seen); else passed++;
    hpd = 1'b1;
  endtask
`else
  task automatic test_debounce();
    bit stayed = 1'b1;
    int n;
    @(negedge clk); hpd = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      @(posedge clk); #1;
      if (i == 500) hpd = 1'b1;
      if (!lup) stayed = 1'b0;
    end
    total++; if (stayed !== 1'b1) $display("FAIL short_glitch: got %b want 1", stayed); else passed++;
    @(negedge clk); hpd = 1'b0;
    repeat (1100) @(posedge clk);
    #1;
    total++; if (lup !== 1'b0) $display("FAIL long_low: got %b want 0", lup); else passed++;
    @(negedge clk); hpd = 1'b1;
    edges_until(1'b1, 1'b1, 3000, n);
    total++; if (n !== 1363) $display("FAIL debounce_reseq: got %0d edges want 1363", n); else passed++;
  endtask
`endif
  task automatic test_async_reset();
    @(negedge clk); hpd = 1'b1; locked = 1'b0;
    @(posedge clk); #1; locked = 1'b1;
    repeat (289) @(posedge clk);
    #1;
    total++; if (srst !== 1'b0) $display("FAIL in_flush_srst: got %b want 0", srst); else passed++;
    total++; if (lup !== 1'b0) $display("FAIL in_flush_link: got %b want 0", lup); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (srst !== 1'b1) $display("FAIL async_srst: got %b want 1", srst); else passed++;
    total++; if (lup !== 1'b0) $display("FAIL async_link: got %b want 0", lup); else passed++;
    total++; if (t0 !== CTL) $display("FAIL async_ch0: got %h want %h", t0, CTL); else passed++;
    total++; if (t1 !== CTL) $display("FAIL async_ch1: got %h want %h", t1, CTL); else passed++;
    total++; if (t2 !== CTL) $display("FAIL async_ch2: got %h want %h", t2, CTL); else passed++;
    test_bringup("restart");
  endtask
  initial begin
    test_reset();
    test_bringup("bringup");
    test_video(8, "video");
    test_lock_glitch();
    test_video(16, "back_to_back");
`ifndef HPD_DEBOUNCE_EN
    test_flush_abort();
`else
    test_debounce();
`endif
    test_async_reset();
    test_video(8, "after_reset");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
